argmax_scheduler: RTL and testbench

- Shares one argmax unit (10 × 16-bit scores in, 4-bit class index out) among several MLP output-layer lanes.
- Round-robin arbitrates among requesting lanes and captures the granted score vector.
- Launches the argmax unit, waits for its result under a timeout watchdog, then returns the class index tagged with the lane ID over a valid/ready result port.
- Sits between the output-layer lanes and the classification result sink.

---
 rtl/argmax_scheduler.sv | 159 +++++++++++++++
 tb/tb_argmax_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_scheduler.sv
// argmax_scheduler
//   Shares one argmax unit among numReq output-layer lanes. A round-robin
//   arbiter grants one requesting lane, its score vector is captured and
//   launched into the argmax unit, the result is awaited under a timeout
//   watchdog, and the class index is returned tagged with the lane ID.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        asynchronous active-high reset
//   i_req_valid  per-lane request valid
//   i_req_data   lane k vector at [k*numInput*inputWidth +: numInput*inputWidth]
//   o_req_ready  one-hot accept strobe (combinational, IDLE only)
//   o_mf_data    captured vector to the argmax unit
//   o_mf_valid   one-cycle launch pulse to the argmax unit
//   i_mf_data    argmax unit class index
//   i_mf_valid   argmax unit result valid (sticky until next launch)
//   o_res_valid  result valid, held until i_res_ready
//   o_res_class  winning class index (4'hF on timeout)
//   o_res_id     lane that issued the request
//   o_res_err    result produced by the watchdog
//   i_res_ready  sink accepts result
//   o_timeout    sticky watchdog flag, cleared only by reset
//   o_busy       high whenever not idle
module argmax_scheduler #(
  parameter int numReq        = 4,
  parameter int idWidth       = 2,
  parameter int numInput      = 10,
  parameter int inputWidth    = 16,
  parameter int timeoutCycles = 32
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [numReq-1:0]                     i_req_valid,
  input  logic [numReq*numInput*inputWidth-1:0] i_req_data,
  output logic [numReq-1:0]                     o_req_ready,
  output logic [numInput*inputWidth-1:0]        o_mf_data,
  output logic                                  o_mf_valid,
  input  logic [3:0]                            i_mf_data,
  input  logic                                  i_mf_valid,
  output logic                                  o_res_valid,
  output logic [3:0]                            o_res_class,
  output logic [idWidth-1:0]                    o_res_id,
  output logic                                  o_res_err,
  input  logic                                  i_res_ready,
  output logic                                  o_timeout,
  output logic                                  o_busy
);

  localparam int VecW = numInput * inputWidth;
  localparam int CntW = $clog2(timeoutCycles + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_RESP} state_t;

  state_t              state;
  state_t              state_nx;
  logic [idWidth-1:0]  ptr;
  logic [CntW-1:0]     wait_cnt;

  logic [2*numReq-1:0] req_rot;
  logic                grant_hit;
  logic [idWidth-1:0]  grant_id;
  logic [idWidth:0]    grant_sum;

  // Rotating the doubled request vector by the pointer turns the circular
  // search into a plain lowest-bit-first scan; the hit offset is then
  // folded back modulo numReq.
  always_comb begin
    req_rot   = {i_req_valid, i_req_valid} >> ptr;
    grant_hit = 1'b0;
    grant_id  = '0;
    grant_sum = '0;
    for (int unsigned i = 0; i < numReq; i++) begin
      if (!grant_hit && req_rot[i]) begin
        grant_hit = 1'b1;
        grant_sum = {1'b0, ptr} + (idWidth+1)'(i);
        if (grant_sum >= (idWidth+1)'(numReq))
          grant_sum = grant_sum - (idWidth+1)'(numReq);
        grant_id = grant_sum[idWidth-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    o_req_ready = '0;
    o_mf_valid  = 1'b0;
    o_busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (grant_hit) begin
          o_req_ready = numReq'(1) << grant_id;
          state_nx    = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        o_mf_valid = 1'b1;
        state_nx   = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_mf_valid || wait_cnt == CntW'(1)) state_nx = ST_RESP;
      end
      ST_RESP: begin
        if (i_res_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr         <= '0;
      o_mf_data   <= '0;
      wait_cnt    <= '0;
      o_res_valid <= 1'b0;
      o_res_class <= '0;
      o_res_id    <= '0;
      o_res_err   <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_hit) begin
            o_mf_data <= i_req_data[grant_id*VecW +: VecW];
            o_res_id  <= grant_id;
          end
        end
        ST_LAUNCH: wait_cnt <= CntW'(timeoutCycles);
        ST_WAIT: begin
          // A real result in the last watchdog cycle still wins.
          if (i_mf_valid) begin
            o_res_class <= i_mf_data;
            o_res_err   <= 1'b0;
            o_res_valid <= 1'b1;
          end else if (wait_cnt == CntW'(1)) begin
            o_res_class <= 4'hF;
            o_res_err   <= 1'b1;
            o_timeout   <= 1'b1;
            o_res_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (i_res_ready) begin
            o_res_valid <= 1'b0;
            ptr <= (o_res_id == idWidth'(numReq - 1)) ? '0 : o_res_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_scheduler.sv
// tb_argmax_scheduler
//   Directed bench for argmax_scheduler with a stand-in argmax unit and a
//   transaction-level reference model checked on every falling edge.
module tb_argmax_scheduler;

  localparam int NR = 4;
  localparam int IW = 2;
  localparam int NI = 10;
  localparam int SW = 16;
  localparam int TO = 32;
  localparam int VW = NI * SW;

  logic             i_clk;
  logic             i_rst;
  logic [NR-1:0]    i_req_valid;
  logic [NR*VW-1:0] i_req_data;
  logic [NR-1:0]    o_req_ready;
  logic [VW-1:0]    o_mf_data;
  logic             o_mf_valid;
  logic [3:0]       i_mf_data;
  logic             i_mf_valid;
  logic             o_res_valid;
  logic [3:0]       o_res_class;
  logic [IW-1:0]    o_res_id;
  logic             o_res_err;
  logic             i_res_ready;
  logic             o_timeout;
  logic             o_busy;

  argmax_scheduler #(
    .numReq(NR), .idWidth(IW), .numInput(NI), .inputWidth(SW), .timeoutCycles(TO)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .i_req_data(i_req_data),
    .o_req_ready(o_req_ready), .o_mf_data(o_mf_data), .o_mf_valid(o_mf_valid),
    .i_mf_data(i_mf_data), .i_mf_valid(i_mf_valid), .o_res_valid(o_res_valid),
    .o_res_class(o_res_class), .o_res_id(o_res_id), .o_res_err(o_res_err),
    .i_res_ready(i_res_ready), .o_timeout(o_timeout), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] argmax_of(input logic [VW-1:0] v);
    int best;
    best = 0;
    for (int i = 1; i < NI; i++)
      if (v[i*SW +: SW] > v[best*SW +: SW]) best = i;
    return 4'(best);
  endfunction

  function automatic int pick(input logic [NR-1:0] req, input int p);
    for (int k = 0; k < NR; k++)
      if (req[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  function automatic logic [VW-1:0] vec_peak(input int p);
    logic [VW-1:0] v;
    for (int i = 0; i < NI; i++) v[i*SW +: SW] = (i == p) ? 16'd1000 : 16'(100 + i);
    return v;
  endfunction

  function automatic logic [VW-1:0] vec_ascending();
    logic [VW-1:0] v;
    for (int i = 0; i < NI; i++) v[i*SW +: SW] = 16'(i);
    return v;
  endfunction

  function automatic logic [VW-1:0] vec_tie37();
    logic [VW-1:0] v;
    for (int i = 0; i < NI; i++) v[i*SW +: SW] = (i == 3 || i == 7) ? 16'd50 : 16'd5;
    return v;
  endfunction

  logic [VW-1:0] lane_vec [NR];
  always_comb
    for (int k = 0; k < NR; k++) i_req_data[k*VW +: VW] = lane_vec[k];

  // Stand-in argmax unit: samples the launch, result valid NI-1 edges later,
  // result sticky until the next launch. force_off suppresses the result.
  bit         force_off = 1'b0;
  logic       am_valid = 1'b0;
  logic [3:0] am_data = '0;
  int         am_cnt = 0;
  bit         am_arm = 1'b0;
  assign i_mf_valid = am_valid;
  assign i_mf_data  = am_data;

  always @(posedge i_clk) begin
    if (o_mf_valid) begin
      am_valid <= 1'b0;
      am_data  <= argmax_of(o_mf_data);
      am_cnt   <= NI - 1;
      am_arm   <= !force_off;
    end else if (am_arm) begin
      if (am_cnt == 1) begin
        am_valid <= 1'b1;
        am_arm   <= 1'b0;
      end
      am_cnt <= am_cnt - 1;
    end
  end

  // Reference model: a transaction timeline. Grant cycle is age 0, launch
  // age 1, result at age NI+2 (or TO+2 on timeout), held until accepted.
  int            cyc = 0;
  bit            m_busy = 1'b0;
  int            m_age = 0;
  int            m_lat = 0;
  int            m_id = 0;
  int            m_ptr = 0;
  bit            m_err = 1'b0;
  bit            m_tout = 1'b0;
  logic [3:0]    m_cls = '0;
  logic [VW-1:0] m_buf = '0;
  logic [NR-1:0] exp_ready;
  int            g;
  bit            prev_rv = 1'b0;

  int         gq[$];
  int         gcq[$];
  logic [3:0] rq_cls[$];
  int         rq_id[$];
  bit         rq_err[$];
  int         rcq[$];
  int         hq[$];

  always @(negedge i_clk) begin
    cyc++;
    if (i_rst) begin
      check("rst_req_ready", o_req_ready, '0);
      check("rst_mf_valid", o_mf_valid, 0);
      check("rst_res_valid", o_res_valid, 0);
      check("rst_busy", o_busy, 0);
      check("rst_timeout", o_timeout, 0);
      check("rst_mf_data", o_mf_data, '0);
      check("rst_res_class", o_res_class, 0);
      check("rst_res_id", o_res_id, 0);
      check("rst_res_err", o_res_err, 0);
      m_busy = 1'b0; m_age = 0; m_ptr = 0; m_tout = 1'b0; m_buf = '0; prev_rv = 1'b0;
    end else begin
      exp_ready = '0;
      g = -1;
      if (!m_busy) begin
        g = pick(i_req_valid, m_ptr);
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      check("req_ready", o_req_ready, exp_ready);
      check("mf_valid", o_mf_valid, m_busy && m_age == 1);
      check("busy", o_busy, m_busy);
      check("res_valid", o_res_valid, m_busy && m_age == m_lat);
      check("timeout_flag", o_timeout, m_tout);
      check("mf_data", o_mf_data, m_buf);
      if (m_busy && m_age == m_lat) begin
        check("res_class", o_res_class, m_cls);
        check("res_id", o_res_id, m_id);
        check("res_err", o_res_err, m_err);
      end

      for (int k = 0; k < NR; k++)
        if (o_req_ready[k]) begin gq.push_back(k); gcq.push_back(cyc); end
      if (o_res_valid && !prev_rv) begin
        rq_cls.push_back(o_res_class); rq_id.push_back(int'(o_res_id));
        rq_err.push_back(o_res_err); rcq.push_back(cyc);
      end
      if (o_res_valid && i_res_ready) hq.push_back(cyc);
      prev_rv = o_res_valid;

      if (!m_busy) begin
        if (g >= 0) begin
          m_busy = 1'b1; m_age = 1; m_id = g; m_buf = lane_vec[g];
          m_err  = force_off;
          m_cls  = force_off ? 4'hF : argmax_of(lane_vec[g]);
          m_lat  = force_off ? TO + 2 : NI + 2;
        end
      end else if (m_age == m_lat) begin
        if (i_res_ready) begin m_busy = 1'b0; m_ptr = (m_id + 1) % NR; end
      end else begin
        m_age++;
        if (m_age == m_lat && m_err) m_tout = 1'b1;
      end
    end
  end

  task automatic drive_req(input int k);
    bit seen;
    seen = 1'b0;
    i_req_valid[k] = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge i_clk);
      if (o_req_ready[k]) seen = 1'b1;
    end
    check("req_accept_wait", seen, 1);
    @(posedge i_clk); #1;
    i_req_valid[k] = 1'b0;
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 400 && rq_cls.size() < n; i++) @(negedge i_clk);
    check("result_wait", rq_cls.size() >= n, 1);
    @(posedge i_clk); #1;
  endtask

  task automatic apply_reset();
    @(posedge i_clk); #3 i_rst = 1'b1;
    @(posedge i_clk); @(posedge i_clk); #3 i_rst = 1'b0;
  endtask

  int order [5] = '{0, 1, 2, 3, 0};
  int clsx  [5] = '{4, 5, 9, 6, 4};
  int gbase;
  int rbase;
  bit seen_rv;

  initial begin
    i_rst = 1'b0; i_req_valid = '0; i_res_ready = 1'b1;
    for (int k = 0; k < NR; k++) lane_vec[k] = '0;
    #1 i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #3 i_rst = 1'b0;

    // single lane 2, ascending scores
    lane_vec[2] = vec_ascending();
    drive_req(2);
    wait_results(1);
    check("t1_grant", gq[$], 2);
    check("t1_class", rq_cls[$], 9);
    check("t1_id", rq_id[$], 2);
    check("t1_err", rq_err[$], 0);
    check("t1_latency", rcq[$] - gcq[$], 12);

    // all lanes continuously from a fresh pointer
    apply_reset();
    lane_vec[0] = vec_peak(4); lane_vec[1] = vec_peak(5); lane_vec[3] = vec_peak(6);
    gbase = gq.size(); rbase = rq_cls.size();
    i_req_valid = '1;
    for (int i = 0; i < 200 && gq.size() < gbase + 5; i++) @(negedge i_clk);
    @(posedge i_clk); #1 i_req_valid = '0;
    wait_results(rbase + 5);
    check("t2_grants", gq.size() >= gbase + 5, 1);
    for (int i = 0; i < 5; i++) begin
      check("t2_order", gq[gbase+i], order[i]);
      check("t2_res_id", rq_id[rbase+i], order[i]);
      check("t2_res_class", rq_cls[rbase+i], clsx[i]);
    end
    for (int i = 0; i < 4; i++) check("t2_spacing", gcq[gbase+i+1] - gcq[gbase+i], 13);

    // max at index 0, then tie at 3 and 7
    lane_vec[0] = vec_peak(0);
    drive_req(0);
    wait_results(rq_cls.size() + 1);
    check("t3_class0", rq_cls[$], 0);
    lane_vec[0] = vec_tie37();
    drive_req(0);
    wait_results(rq_cls.size() + 1);
    check("t3_tie", rq_cls[$], 3);

    // result sink stalls while another lane requests
    i_res_ready = 1'b0;
    lane_vec[1] = vec_peak(7); lane_vec[3] = vec_peak(2);
    drive_req(1);
    seen_rv = 1'b0;
    for (int i = 0; i < 50 && !seen_rv; i++) begin
      @(negedge i_clk);
      seen_rv = o_res_valid;
    end
    check("t4_rv_wait", seen_rv, 1);
    i_req_valid[3] = 1'b1;
    repeat (20) @(negedge i_clk);
    check("t4_hold_valid", o_res_valid, 1);
    check("t4_hold_class", o_res_class, 7);
    check("t4_hold_id", o_res_id, 1);
    @(posedge i_clk); #1 i_res_ready = 1'b1;
    drive_req(3);
    check("t4_next_grant", gq[$], 3);
    check("t4_idle_gap", gcq[$] - hq[$], 1);
    wait_results(rq_cls.size() + 1);
    check("t4_class", rq_cls[$], 2);

    // watchdog timeout, then a good result with the flag still set
    force_off = 1'b1;
    drive_req(2);
    wait_results(rq_cls.size() + 1);
    force_off = 1'b0;
    check("t5_class", rq_cls[$], 4'hF);
    check("t5_err", rq_err[$], 1);
    check("t5_latency", rcq[$] - gcq[$], 34);
    check("t5_flag", o_timeout, 1);
    lane_vec[0] = vec_peak(0);
    drive_req(0);
    wait_results(rq_cls.size() + 1);
    check("t5_good_class", rq_cls[$], 0);
    check("t5_good_err", rq_err[$], 0);
    check("t5_sticky", o_timeout, 1);

    // reset during WAIT, then lane 1 served normally
    lane_vec[1] = vec_peak(8);
    drive_req(1);
    repeat (5) @(posedge i_clk);
    #3 i_rst = 1'b1;
    #1;
    check("t6_async_busy", o_busy, 0);
    check("t6_async_timeout", o_timeout, 0);
    check("t6_async_mf_data", o_mf_data, '0);
    check("t6_async_res_id", o_res_id, 0);
    @(posedge i_clk); @(posedge i_clk); #3 i_rst = 1'b0;
    drive_req(1);
    wait_results(rq_cls.size() + 1);
    check("t6_grant", gq[$], 1);
    check("t6_class", rq_cls[$], 8);
    check("t6_id", rq_id[$], 1);
    check("t6_err", rq_err[$], 0);
    check("t6_latency", rcq[$] - gcq[$], 12);

    repeat (3) @(posedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
